// File: rtl/signal_conflict_monitor.sv
// Safety stage between the traffic-light FSM and the lamp drivers: checks lamp vectors and forces flashing red on fault.
// Define SIGNAL_MON_SEQ_CHECK_EN to build the colour-sequence and short-yellow checks with their dwell counters.
module signal_conflict_monitor #(
    parameter int unsigned MIN_YELLOW = 4,
    parameter int unsigned FLASH_HALF = 8,
    parameter int unsigned CLR_HOLD   = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] light_north_south,
    input  logic [2:0] light_east_west,
    input  logic       fault_clear,
    output logic [2:0] lamp_ns,
    output logic [2:0] lamp_ew,
    output logic       fault,
    output logic [2:0] fault_code
);
    localparam int unsigned LAMP_W  = 3;
    localparam int unsigned CODE_W  = 3;
    localparam int unsigned FLASH_W = $clog2(2 * FLASH_HALF);
    localparam int unsigned CLR_W   = $clog2(CLR_HOLD + 1);

    localparam logic [LAMP_W-1:0] RED  = 3'b100;
    localparam logic [LAMP_W-1:0] YEL  = 3'b010;
    localparam logic [LAMP_W-1:0] GRN  = 3'b001;
    localparam logic [LAMP_W-1:0] DARK = 3'b000;

    localparam logic [CODE_W-1:0] CODE_NONE     = CODE_W'(0);
    localparam logic [CODE_W-1:0] CODE_ENC      = CODE_W'(1);
    localparam logic [CODE_W-1:0] CODE_CONFLICT = CODE_W'(2);
    localparam logic [CODE_W-1:0] CODE_SEQ      = CODE_W'(3);
    localparam logic [CODE_W-1:0] CODE_SHORT_Y  = CODE_W'(4);

    if (MIN_YELLOW == 0 || FLASH_HALF == 0 || CLR_HOLD == 0) begin : g_bad_cfg
        $error("signal_conflict_monitor: MIN_YELLOW, FLASH_HALF and CLR_HOLD must be non-zero");
    end

    typedef enum logic [1:0] {ST_INIT, ST_MONITOR, ST_FAULT, ST_CLEARING} state_t;

    state_t              state_q, state_n;
    logic [LAMP_W-1:0]   in_ns_q, in_ew_q;
    logic [LAMP_W-1:0]   lamp_ns_n, lamp_ew_n, flash_lamp;
    logic                fault_n;
    logic [CODE_W-1:0]   code_n, code_pick;
    logic [FLASH_W-1:0]  flash_q, flash_n, flash_adv;
    logic [CLR_W-1:0]    clr_q, clr_n;
    logic                enc_err, conf_err, seq_err, short_err, clean;

    function automatic logic is_legal(input logic [LAMP_W-1:0] v);
        return (v == RED) || (v == YEL) || (v == GRN);
    endfunction

    assign enc_err   = !is_legal(in_ns_q) || !is_legal(in_ew_q);
    assign conf_err  = (in_ns_q != RED) && (in_ew_q != RED);
    assign clean     = !enc_err && !conf_err;
    assign code_pick = enc_err  ? CODE_ENC :
                       conf_err ? CODE_CONFLICT :
                       seq_err  ? CODE_SEQ : CODE_SHORT_Y;

    // Flash phase for the cycle being registered; on phase occupies the first half of the period
    assign flash_adv  = (flash_q == FLASH_W'(2 * FLASH_HALF - 1)) ? '0 : flash_q + FLASH_W'(1);
    assign flash_lamp = (flash_adv < FLASH_W'(FLASH_HALF)) ? RED : DARK;

`ifdef SIGNAL_MON_SEQ_CHECK_EN
    localparam int unsigned DWELL_W = $clog2(MIN_YELLOW + 1);

    logic [LAMP_W-1:0]  prev_ns_q, prev_ew_q;
    logic [DWELL_W-1:0] dwell_ns_q, dwell_ew_q;
    logic               exempt_ns_q, exempt_ew_q;
    logic               restart;

    function automatic logic step_ok(input logic [LAMP_W-1:0] p, input logic [LAMP_W-1:0] c);
        return (p == c) || (p == GRN && c == YEL) || (p == YEL && c == RED) || (p == RED && c == GRN);
    endfunction

    function automatic logic [DWELL_W-1:0] dwell_next(input logic [LAMP_W-1:0] c,
                                                      input logic [DWELL_W-1:0] d);
        if (c != YEL) return '0;
        if (d == DWELL_W'(MIN_YELLOW)) return d;
        return d + DWELL_W'(1);
    endfunction

    assign restart   = (state_q == ST_CLEARING) && (state_n == ST_INIT);
    assign seq_err   = !step_ok(prev_ns_q, in_ns_q) || !step_ok(prev_ew_q, in_ew_q);
    assign short_err = (prev_ns_q == YEL && in_ns_q == RED && dwell_ns_q < DWELL_W'(MIN_YELLOW) && !exempt_ns_q) ||
                       (prev_ew_q == YEL && in_ew_q == RED && dwell_ew_q < DWELL_W'(MIN_YELLOW) && !exempt_ew_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_ns_q <= RED;
            prev_ew_q <= RED;
        end else begin
            prev_ns_q <= in_ns_q;
            prev_ew_q <= in_ew_q;
        end
    end

    // A yellow already showing during INIT is exempt until that approach leaves yellow
    always_ff @(posedge clk) begin
        if (reset || restart) begin
            dwell_ns_q  <= '0;
            dwell_ew_q  <= '0;
            exempt_ns_q <= 1'b0;
            exempt_ew_q <= 1'b0;
        end else begin
            dwell_ns_q  <= dwell_next(in_ns_q, dwell_ns_q);
            dwell_ew_q  <= dwell_next(in_ew_q, dwell_ew_q);
            exempt_ns_q <= (in_ns_q == YEL) && (exempt_ns_q || state_q == ST_INIT);
            exempt_ew_q <= (in_ew_q == YEL) && (exempt_ew_q || state_q == ST_INIT);
        end
    end
`else
    assign seq_err   = 1'b0;
    assign short_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_INIT;
        else       state_q <= state_n;
    end

    always_comb begin
        state_n   = state_q;
        lamp_ns_n = lamp_ns;
        lamp_ew_n = lamp_ew;
        fault_n   = fault;
        code_n    = fault_code;
        flash_n   = flash_q;
        clr_n     = clr_q;
        case (state_q)
            ST_INIT: begin
                lamp_ns_n = RED;
                lamp_ew_n = RED;
                if (!clean) begin
                    state_n = ST_FAULT;
                    fault_n = 1'b1;
                    code_n  = code_pick;
                    flash_n = '0;
                end else begin
                    state_n = ST_MONITOR;
                end
            end
            ST_MONITOR: begin
                if (!clean || seq_err || short_err) begin
                    state_n   = ST_FAULT;
                    fault_n   = 1'b1;
                    code_n    = code_pick;
                    flash_n   = '0;
                    lamp_ns_n = RED;
                    lamp_ew_n = RED;
                end else begin
                    lamp_ns_n = in_ns_q;
                    lamp_ew_n = in_ew_q;
                end
            end
            ST_FAULT: begin
                flash_n   = flash_adv;
                lamp_ns_n = flash_lamp;
                lamp_ew_n = flash_lamp;
                if (fault_clear) begin
                    state_n = ST_CLEARING;
                    clr_n   = '0;
                end
            end
            ST_CLEARING: begin
                flash_n   = flash_adv;
                lamp_ns_n = flash_lamp;
                lamp_ew_n = flash_lamp;
                if (!clean) begin
                    clr_n = '0;
                end else if (clr_q == CLR_W'(CLR_HOLD - 1)) begin
                    state_n   = ST_INIT;
                    fault_n   = 1'b0;
                    code_n    = CODE_NONE;
                    clr_n     = '0;
                    flash_n   = '0;
                    lamp_ns_n = RED;
                    lamp_ew_n = RED;
                end else begin
                    clr_n = clr_q + CLR_W'(1);
                end
            end
            default: state_n = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            in_ns_q    <= RED;
            in_ew_q    <= RED;
            lamp_ns    <= RED;
            lamp_ew    <= RED;
            fault      <= 1'b0;
            fault_code <= CODE_NONE;
            flash_q    <= '0;
            clr_q      <= '0;
        end else begin
            in_ns_q    <= light_north_south;
            in_ew_q    <= light_east_west;
            lamp_ns    <= lamp_ns_n;
            lamp_ew    <= lamp_ew_n;
            fault      <= fault_n;
            fault_code <= code_n;
            flash_q    <= flash_n;
            clr_q      <= clr_n;
        end
    end

endmodule

// File: tb/tb_signal_conflict_monitor.sv
// Randomized self-checking bench for signal_conflict_monitor against a history-based reference model.
module tb_signal_conflict_monitor;
    localparam int unsigned MIN_YELLOW = 4;
    localparam int unsigned FLASH_HALF = 8;
    localparam int unsigned CLR_HOLD   = 16;
    localparam int NMAX = 4096;

`ifdef SIGNAL_MON_SEQ_CHECK_EN
    localparam bit SEQ_EN = 1'b1;
`else
    localparam bit SEQ_EN = 1'b0;
`endif

    localparam logic [2:0] R = 3'b100, Y = 3'b010, G = 3'b001;
    localparam int M_INIT = 0, M_MON = 1, M_FAULT = 2, M_CLR = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] light_north_south, light_east_west;
    logic       fault_clear;
    logic [2:0] lamp_ns, lamp_ew, fault_code;
    logic       fault;

    signal_conflict_monitor #(
        .MIN_YELLOW(MIN_YELLOW), .FLASH_HALF(FLASH_HALF), .CLR_HOLD(CLR_HOLD)
    ) dut (
        .clk(clk), .reset(reset),
        .light_north_south(light_north_south), .light_east_west(light_east_west),
        .fault_clear(fault_clear),
        .lamp_ns(lamp_ns), .lamp_ew(lamp_ew), .fault(fault), .fault_code(fault_code)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model state: per-edge history of sampled inputs plus a few event markers
    logic [2:0] hn [NMAX];
    logic [2:0] he [NMAX];
    int k = 0;
    int m = M_INIT;
    int init_idx = 0, fault_edge = 0, clr_start = 0;
    logic [2:0] e_ns = R, e_ew = R, e_code = 3'd0;
    logic       e_fault = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit ok3(input logic [2:0] v);
        return v == R || v == Y || v == G;
    endfunction

    function automatic bit step_ok(input logic [2:0] p, input logic [2:0] c);
        return p == c || (p == G && c == Y) || (p == Y && c == R) || (p == R && c == G);
    endfunction

    function automatic bit legal_pair(input int j);
        return ok3(hn[j]) && ok3(he[j]) && (hn[j] == R || he[j] == R);
    endfunction

    // Yellow->red at edge kk whose yellow run was too short and did not overlap the INIT cycle
    function automatic bit short_y(input bit is_ns, input int kk);
        int j;
        int len;
        logic [2:0] cur, prv;
        cur = is_ns ? hn[kk-1] : he[kk-1];
        prv = is_ns ? hn[kk-2] : he[kk-2];
        if (!(prv == Y && cur == R)) return 1'b0;
        len = 0;
        j = kk - 2;
        while (j >= 0 && (is_ns ? hn[j] : he[j]) == Y) begin
            len++;
            j--;
        end
        if (j + 1 <= init_idx) return 1'b0;
        return len < int'(MIN_YELLOW);
    endfunction

    task automatic enter_fault(input int c);
        m = M_FAULT;
        fault_edge = k;
        e_fault = 1'b1;
        e_code = 3'(c);
        e_ns = R;
        e_ew = R;
    endtask

    task automatic flash_out();
        e_ns = (((k - fault_edge) / int'(FLASH_HALF)) % 2 == 0) ? R : 3'b000;
        e_ew = e_ns;
    endtask

    task automatic model_edge(input logic [2:0] ns, input logic [2:0] ew, input logic clr, input logic rst);
        logic [2:0] cn, ce, pn, pe;
        bit enc, conf, sq, sy;
        int code, run;
        if (k >= NMAX) begin
            bad++;
            $display("FAIL model_depth: edge %0d exceeds history %0d", k, NMAX);
            $fatal(1, "history overflow");
        end
        if (rst) begin
            hn[k] = R; he[k] = R;
            m = M_INIT;
            e_ns = R; e_ew = R; e_fault = 1'b0; e_code = 3'd0;
            k++;
            return;
        end
        hn[k] = ns; he[k] = ew;
        cn = hn[k-1]; ce = he[k-1]; pn = hn[k-2]; pe = he[k-2];
        enc  = !ok3(cn) || !ok3(ce);
        conf = (cn != R) && (ce != R);
        sq   = !step_ok(pn, cn) || !step_ok(pe, ce);
        sy   = short_y(1'b1, k) || short_y(1'b0, k);
        case (m)
            M_INIT: begin
                init_idx = k - 1;
                e_ns = R; e_ew = R;
                if (enc) enter_fault(1);
                else if (conf) enter_fault(2);
                else m = M_MON;
            end
            M_MON: begin
                code = enc ? 1 : conf ? 2 : (SEQ_EN && sq) ? 3 : (SEQ_EN && sy) ? 4 : 0;
                if (code != 0) enter_fault(code);
                else begin
                    e_ns = cn; e_ew = ce;
                end
            end
            M_FAULT: begin
                flash_out();
                if (clr) begin
                    m = M_CLR;
                    clr_start = k;
                end
            end
            default: begin
                run = 0;
                for (int j = k - 1; j >= clr_start && legal_pair(j); j--) run++;
                if (run >= int'(CLR_HOLD)) begin
                    m = M_INIT;
                    e_fault = 1'b0; e_code = 3'd0; e_ns = R; e_ew = R;
                end else begin
                    flash_out();
                end
            end
        endcase
        k++;
    endtask

    task automatic cyc(input logic [2:0] ns, input logic [2:0] ew, input logic clr, input logic rst);
        light_north_south = ns;
        light_east_west   = ew;
        fault_clear       = clr;
        reset             = rst;
        @(posedge clk);
        model_edge(ns, ew, clr, rst);
        #1;
        check("lamp_ns", 32'(lamp_ns), 32'(e_ns));
        check("lamp_ew", 32'(lamp_ew), 32'(e_ew));
        check("fault", 32'(fault), 32'(e_fault));
        check("fault_code", 32'(fault_code), 32'(e_code));
    endtask

    task automatic hold(input logic [2:0] ns, input logic [2:0] ew, input int n);
        for (int i = 0; i < n; i++) cyc(ns, ew, 1'b0, 1'b0);
    endtask

    task automatic recover();
        hold(R, R, 3);
        cyc(R, R, 1'b1, 1'b0);
        hold(R, R, CLR_HOLD + 4);
    endtask

    initial begin
        int ph, dw;
        logic [2:0] n, e;
        logic c, r;

        for (int i = 0; i < 3; i++) cyc(R, R, 1'b0, 1'b1);
        check("rst_fault", 32'(fault), 32'd0);
        check("rst_lamp", 32'(lamp_ns), 32'(R));

        // legal cycling, 11 cycles per phase
        for (int rep = 0; rep < 3; rep++) begin
            hold(G, R, 11);
            hold(Y, R, 11);
            hold(R, G, 11);
            hold(R, Y, 11);
        end
        check("legal_fault", 32'(fault), 32'd0);

        // conflicting greens, then clear with an encoding glitch at clearing cycle 10
        hold(R, R, 2);
        cyc(G, G, 1'b0, 1'b0);
        cyc(R, R, 1'b0, 1'b0);
        check("conf_fault", 32'(fault), 32'd1);
        check("conf_code", 32'(fault_code), 32'd2);
        hold(R, R, 20);
        cyc(R, R, 1'b1, 1'b0);
        hold(R, R, 8);
        cyc(3'b011, R, 1'b0, 1'b0);
        hold(R, R, 15);
        check("clr_code_kept", 32'(fault_code), 32'd2);
        cyc(R, R, 1'b0, 1'b0);
        check("clr_hold", 32'(fault), 32'd1);
        cyc(R, R, 1'b0, 1'b0);
        check("clr_exit_fault", 32'(fault), 32'd0);
        check("clr_exit_code", 32'(fault_code), 32'd0);
        hold(G, R, 4);
        check("clr_follow", 32'(lamp_ns), 32'(G));

        // encoding beats conflict
        hold(R, R, 2);
        cyc(3'b011, G, 1'b0, 1'b0);
        cyc(R, R, 1'b0, 1'b0);
        check("enc_code", 32'(fault_code), 32'd1);
        recover();

        // green straight to red
        hold(G, R, 3);
        cyc(R, R, 1'b0, 1'b0);
        cyc(R, R, 1'b0, 1'b0);
        check("seq_code", 32'(fault_code), SEQ_EN ? 32'd3 : 32'd0);
        recover();

        // two-cycle yellow
        hold(G, R, 3);
        hold(Y, R, 2);
        cyc(R, R, 1'b0, 1'b0);
        cyc(R, R, 1'b0, 1'b0);
        check("shorty_code", 32'(fault_code), SEQ_EN ? 32'd4 : 32'd0);
        recover();

        // exactly MIN_YELLOW yellow cycles is acceptable
        hold(G, R, 3);
        hold(Y, R, MIN_YELLOW);
        cyc(R, R, 1'b0, 1'b0);
        cyc(R, R, 1'b0, 1'b0);
        check("y4_fault", 32'(fault), 32'd0);
        recover();

        // random legal cycling with glitches, random clears and occasional reset
        ph = 3;
        dw = 0;
        for (int i = 0; i < 900; i++) begin
            if (dw == 0) begin
                ph = (ph + 1) % 4;
                dw = $urandom_range(1, 7);
            end
            dw--;
            case (ph)
                0:       begin n = G; e = R; end
                1:       begin n = Y; e = R; end
                2:       begin n = R; e = G; end
                default: begin n = R; e = Y; end
            endcase
            if ($urandom_range(0, 49) == 0) begin
                n = 3'($urandom);
                e = 3'($urandom);
            end
            c = ($urandom_range(0, 11) == 0);
            r = ($urandom_range(0, 299) == 0);
            cyc(n, e, c, r);
        end
        recover();

        // reset in the middle of a flash
        hold(R, R, 2);
        cyc(G, G, 1'b0, 1'b0);
        hold(R, R, 5);
        check("mid_fault", 32'(fault), 32'd1);
        cyc(R, R, 1'b0, 1'b1);
        check("rstmid_fault", 32'(fault), 32'd0);
        check("rstmid_code", 32'(fault_code), 32'd0);
        check("rstmid_lamp_ns", 32'(lamp_ns), 32'(R));
        check("rstmid_lamp_ew", 32'(lamp_ew), 32'(R));
        hold(R, G, 6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/signal_conflict_monitor.md
# signal_conflict_monitor

- Safety stage directly downstream of the traffic-light FSM.
- Consumes the FSM's NS/EW lamp vectors, checks them for illegal encodings, conflicting greens, illegal colour sequences and short yellows, and drives the physical lamp outputs.
- On any violation it latches a fault code and forces both approaches into flashing red until an operator clear and a stable legal input window occur.

## Interface
- `MIN_YELLOW`, 4: minimum consecutive yellow cycles before red.
- `FLASH_HALF`, 8: cycles per on/off half-period of the fault flash.
- `CLR_HOLD`, 16: consecutive legal input cycles required to leave fault.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `light_north_south` in 3: FSM NS vector {Red,Yellow,Green}.
- `light_east_west` in 3: FSM EW vector {Red,Yellow,Green}.
- `fault_clear` in 1: operator clear request; level-sampled, honoured only in FAULT.
- `lamp_ns` out 3: NS lamp drive {R,Y,G}.
- `lamp_ew` out 3: EW lamp drive {R,Y,G}.
- `fault` out 1: high while in FAULT or CLEARING.
- `fault_code` out 3: first detected fault. 0 none, 1 ENC, 2 CONFLICT, 3 SEQ, 4 SHORT_Y.

## Operation
- Inputs are registered every cycle into `in_q`, and `in_q` is copied into `prev_q`. Both reset to 100/100.
- **Checks**, evaluated combinationally on `in_q` and `prev_q`:
  - ENC: either vector is not exactly 001, 010 or 100.
  - CONFLICT: both vectors non-red.
  - SEQ: per approach, a change other than G→Y, Y→R or R→G.
  - SHORT_Y: a Y→R change after fewer than `MIN_YELLOW` yellow cycles.
- **Priority** on the same cycle: ENC > CONFLICT > SEQ > SHORT_Y. Only the winning code is latched.
- **Yellow dwell counters:** one per approach. Counts consecutive cycles `in_q` is yellow, saturates at `MIN_YELLOW`, clears when not yellow. Width is `$clog2(MIN_YELLOW+1)`.
- **States:**
  - INIT: reset entry. Lamps 100/100, `fault`=0. Runs the ENC/CONFLICT checks only; SEQ/SHORT_Y are waived. A yellow interval in progress during INIT is exempt from SHORT_Y. Goes to MONITOR after 1 cycle, or to FAULT if a check fires.
  - MONITOR: `lamp_*` <= `in_q` while no check fires. Any check firing goes to FAULT and latches `fault_code`.
  - FAULT: `fault`=1. Lamps flash 100/100 for `FLASH_HALF` cycles, then 000/000 for `FLASH_HALF`, repeating and starting in the on phase. `fault_clear`=1 goes to CLEARING.
  - CLEARING: flashing continues uninterrupted. A counter increments on each cycle where `in_q` passes ENC and CONFLICT, and resets to 0 on any failing cycle. Reaching `CLR_HOLD` goes to INIT, clearing `fault` and `fault_code` and resetting all counters.
- `fault_code` keeps the first fault; later violations in FAULT/CLEARING do not overwrite it.
- `fault_clear` is ignored in INIT and MONITOR.

## Timing
- Reset values: `lamp_ns`=`lamp_ew`=3'b100, `fault`=0, `fault_code`=0, state INIT, all counters 0.
- Input to lamp latency is 2 cycles in MONITOR.
- A fault-causing input at edge t gives `fault`=1 and lamps=100/100 at edge t+2. The offending combination never reaches `lamp_*`.
- Flash phase counter restarts at FAULT entry. FAULT→CLEARING does not restart it.
- CLEARING→INIT occurs on the edge after the `CLR_HOLD`-th legal cycle. MONITOR resumes one cycle later.
- `reset` overrides everything in any state, including mid-flash and mid-CLEARING.
- A violation and `fault_clear` in the same MONITOR cycle: the violation wins and the clear is ignored.

## Configuration
- `SIGNAL_MON_SEQ_CHECK_EN` defined: the SEQ and SHORT_Y checks and the yellow dwell counters are built.
- Undefined: only ENC and CONFLICT are checked, codes 3/4 are never produced, and the dwell counters are absent.

## Test plan
- **Legal run:** drive NS G/EW R 11 cycles, NS Y 11, NS R/EW G 11, EW Y 11, repeated ×3 → `fault`=0 throughout; lamps equal inputs delayed exactly 2 cycles.
- **Conflict:** NS=001, EW=001 for 1 cycle in MONITOR → 2 cycles later `fault`=1, `fault_code`=2; lamps 100/100 for 8 cycles, then 000/000 for 8; lamps never show 001.
- **Encoding priority:** NS=011 with EW=001 on the same cycle → `fault_code`=1.
- **Sequence/dwell (macro defined):**
  - NS 001→100 directly → code 3.
  - NS yellow 2 cycles then red → code 4.
  - NS yellow exactly 4 cycles then red → no fault.
  - With the macro undefined, the first two cases produce no fault.
- **Clear:** in FAULT, pulse `fault_clear` with inputs 100/100, inject NS=011 at clearing cycle 10, then legal inputs → exit only after 16 further consecutive legal cycles; then `fault`=0, `fault_code`=0, lamps follow inputs 2 cycles after MONITOR entry.
- **Reset mid-fault:** assert `reset` for 1 cycle during FAULT flash → next edge lamps 100/100, `fault`=0, `fault_code`=0, state INIT.
